// File: rtl/controle_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package controle_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } estado_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CL_LOAD,
        CL_STORE,
        CL_OP,
        CL_OPIMM,
        CL_BRANCH,
        CL_ILLEGAL
    } classe_t;

    localparam logic [1:0] ERRO_NONE    = 2'd0;
    localparam logic [1:0] ERRO_ILEGAL  = 2'd1;
    localparam logic [1:0] ERRO_TIMEOUT = 2'd2;

endpackage

// File: rtl/decodificador_instrucao.sv
// Combinational instruction classifier: maps IR opcode/funct fields to a class
// and a legality bit.
module decodificador_instrucao
    import controle_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output classe_t    classe_o,
    output logic       legal_o
);

    always_comb begin
        classe_o = CL_ILLEGAL;
        legal_o  = 1'b0;
        case (opcode_i)
            OP_LOAD: begin
                classe_o = CL_LOAD;
                legal_o  = 1'b1;
            end
            OP_STORE: begin
                classe_o = CL_STORE;
                legal_o  = 1'b1;
            end
            OP_R: begin
                classe_o = CL_OP;
                legal_o  = (funct7_i == 7'b0000000) || (funct7_i == 7'b0100000);
            end
            OP_IMM: begin
                classe_o = CL_OPIMM;
                legal_o  = 1'b1;
            end
            OP_BRANCH: begin
                // funct3 010/011 are unassigned branch encodings
                classe_o = CL_BRANCH;
                legal_o  = (funct3_i != 3'b010) && (funct3_i != 3'b011);
            end
            default: begin
                classe_o = CL_ILLEGAL;
                legal_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on the data
// memory with a timeout, and counts retired instructions.
module unidade_controle
    import controle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             flag,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             mux1_sel,
    output logic             mux2_sel,
    output logic             pc_src,
    output logic             halted,
    output logic [1:0]       erro,
    output logic [2:0]       estado,
    output logic [CNT_W-1:0] instr_count
);

    localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    estado_t           estado_q, estado_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        erro_q, erro_d;
    logic [CNT_W-1:0]  count_q, count_d;

    classe_t classe;
    logic    legal;
    logic    retire;
    logic    pc_we_c, ir_we_c, rf_we_c, req_c, we_c, mux1_c, mux2_c, src_c;

    decodificador_instrucao u_dec (
        .opcode_i (opcode),
        .funct3_i (funct3),
        .funct7_i (funct7),
        .classe_o (classe),
        .legal_o  (legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= S_FETCH;
            wait_q   <= '0;
            erro_q   <= ERRO_NONE;
            count_q  <= '0;
        end else begin
            estado_q <= estado_d;
            wait_q   <= wait_d;
            erro_q   <= erro_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        wait_d   = wait_q;
        erro_d   = erro_q;
        retire   = 1'b0;
        pc_we_c  = 1'b0;
        ir_we_c  = 1'b0;
        rf_we_c  = 1'b0;
        req_c    = 1'b0;
        we_c     = 1'b0;
        mux1_c   = 1'b0;
        mux2_c   = 1'b0;
        src_c    = 1'b0;
        case (estado_q)
            S_FETCH: begin
                ir_we_c  = 1'b1;
                estado_d = S_DECODE;
            end
            S_DECODE: begin
                if (!legal) begin
                    estado_d = S_HALT;
                    erro_d   = ERRO_ILEGAL;
                end else begin
                    estado_d = S_EXEC;
                end
            end
            S_EXEC: begin
                mux1_c = (classe == CL_OP) || (classe == CL_BRANCH);
                case (classe)
                    CL_BRANCH: begin
                        pc_we_c  = 1'b1;
                        src_c    = flag;
                        retire   = 1'b1;
                        estado_d = S_FETCH;
                    end
                    CL_OP, CL_OPIMM:   estado_d = S_WB;
                    CL_LOAD, CL_STORE: estado_d = S_MEM;
                    default: begin
                        estado_d = S_HALT;
                        erro_d   = ERRO_ILEGAL;
                    end
                endcase
            end
            S_MEM: begin
                req_c = 1'b1;
                we_c  = (classe == CL_STORE);
                // ready wins over timeout when both land in the same cycle
                if (dmem_ready) begin
                    wait_d = '0;
                    if (classe == CL_STORE) begin
                        pc_we_c  = 1'b1;
                        retire   = 1'b1;
                        estado_d = S_FETCH;
                    end else begin
                        estado_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    wait_d   = '0;
                    estado_d = S_HALT;
                    erro_d   = ERRO_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we_c  = 1'b1;
                mux2_c   = (classe != CL_LOAD);
                pc_we_c  = 1'b1;
                retire   = 1'b1;
                estado_d = S_FETCH;
            end
            S_HALT:  estado_d = S_HALT;
            default: estado_d = S_HALT;
        endcase
        count_d = (retire && (count_q != {CNT_W{1'b1}})) ? count_q + CNT_W'(1) : count_q;
    end

    assign pc_we       = pc_we_c & ~reset;
    assign ir_we       = ir_we_c & ~reset;
    assign rf_we       = rf_we_c & ~reset;
    assign dmem_req    = req_c   & ~reset;
    assign dmem_we     = we_c    & ~reset;
    assign mux1_sel    = mux1_c  & ~reset;
    assign mux2_sel    = mux2_c  & ~reset;
    assign pc_src      = src_c   & ~reset;
    assign halted      = (estado_q == S_HALT);
    assign erro        = erro_q;
    assign estado      = estado_q;
    assign instr_count = count_q;

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit sequencing the RISC-V datapath: PC, IR, register bank, ULA, data memory, immediate generator and Mux1/Mux2/Mux3. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives every write enable and mux select. It handshakes with a variable-latency data memory and halts on illegal encodings or memory timeout. It sits beside the datapath and takes opcode/funct fields from IR and the branch flag from ULA.

## Interface
- MEM_TIMEOUT, 16: max cycles spent in MEM waiting for dmem_ready before error halt.
- CNT_W, 32: width of retired-instruction counter.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- flag  in  1  ULA branch-taken flag.
- dmem_ready  in  1  data memory done (read data valid / write accepted).
- pc_we  out  1  PC load enable.
- ir_we  out  1  IR load enable.
- rf_we  out  1  register bank write enable.
- dmem_req  out  1  data memory access request.
- dmem_we  out  1  data memory write (valid only with dmem_req).
- mux1_sel  out  1  0 = immediate, 1 = Rb to ULA.
- mux2_sel  out  1  0 = memory dout, 1 = ULA result to register bank.
- pc_src  out  1  Mux3 select: 0 = PC+4, 1 = PC+imm.
- halted  out  1  sticky halt indication.
- erro  out  2  halt cause: 0 none, 1 illegal instruction, 2 memory timeout.
- estado  out  3  current state code (debug).
- instr_count  out  CNT_W  retired instructions, saturating.

## Operation
- Instruction classes: LOAD 0000011, STORE 0100011, OP 0110011 (funct7 0000000 or 0100000 only), OPIMM 0010011, BRANCH 1100011 (funct3 in {000,001,100,101,110,111}). Anything else is illegal.
- States and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: ir_we=1. Next state is DECODE.
- DECODE: all enables 0, so the register bank performs its synchronous read. Illegal instruction: HALT with erro=1. Otherwise next state is EXEC.
- EXEC: mux1_sel=1 for OP/BRANCH, 0 otherwise.
  - BRANCH: pc_we=1, pc_src=flag, retire, next FETCH.
  - OP/OPIMM: next WB.
  - LOAD/STORE: next MEM.
- MEM: dmem_req=1, dmem_we=1 for STORE. The wait counter increments each cycle without dmem_ready.
  - On dmem_ready, LOAD: next WB.
  - On dmem_ready, STORE: pc_we=1, pc_src=0, retire, next FETCH.
  - If the counter reaches MEM_TIMEOUT with no ready: HALT with erro=2.
- WB: rf_we=1, mux2_sel=0 for LOAD and 1 otherwise, pc_we=1, pc_src=0, retire, next FETCH.
- HALT: all enables 0 and halted=1. The block stays in HALT until reset.
- Retire: instr_count+1, saturating at 2^CNT_W-1.
- Outputs not listed for a state are 0.

## Timing
- Reset sampled on a clk edge.
  - After reset: estado=FETCH, instr_count=0, halted=0, erro=0, wait counter=0.
  - While reset is high, every enable and dmem_req is forced to 0 combinationally.
  - Reset mid-instruction aborts it with no retire.
- Outputs are decoded from state plus the IR fields. IR is stable from DECODE onward.
- flag is sampled in the EXEC cycle only.
- Cycles per instruction, counted from the FETCH cycle:
  - BRANCH: 3.
  - OP/OPIMM: 4.
  - STORE: 3 + w.
  - LOAD: 4 + w.
  - w is the number of MEM cycles, including the ready cycle (minimum 1).
- dmem_ready outside MEM is ignored.
- dmem_req stays high and dmem_we stays stable until the ready cycle.
- A timeout cycle that coincides with dmem_ready counts as success.

## Structure
- Package controle_pkg holds:
  - state enum;
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH;
  - class enum;
  - erro codes.
- One combinational sub-module, decodificador_instrucao: takes opcode/funct3/funct7 and produces the instruction class and a legal bit.
- The FSM, wait counter and retire counter stay in unidade_controle.

## Test plan
- ADD (opcode 0110011, funct7 0) after reset:
  - ir_we in cycle 0;
  - mux1_sel=1 in cycle 2;
  - rf_we=1, mux2_sel=1, pc_we=1 in cycle 3;
  - instr_count=1.
- BEQ with flag=1 in EXEC: pc_we=1 and pc_src=1 in cycle 2, back to FETCH in cycle 3. Repeat with flag=0: pc_src=0.
- LOAD with dmem_ready delayed 3 cycles:
  - dmem_req high for 3 MEM cycles, dmem_we=0;
  - then WB with mux2_sel=0, rf_we=1;
  - total 7 cycles.
- STORE with dmem_ready never asserted, MEM_TIMEOUT=16:
  - HALT after 16 MEM cycles, halted=1, erro=2;
  - no retire;
  - enables stay 0 thereafter.
- Illegal opcode 1111111, and separately BRANCH funct3=010: HALT from DECODE, erro=1.
- Reset asserted in the MEM cycle of a load: next cycle estado=0, all enables 0, instr_count unchanged from the value before the load (0 if first).
